note_detector: RTL

- Receive-side counterpart to the piano tone generators. Measures the period of an incoming square-wave tone and identifies which of the seven notes (Do..Si) it is.
- Tone input is asynchronous to clk. Results feed the display/scoring logic.
- Clock is 50 MHz; note periods are the full periods the team's tone generators emit.

---
 rtl/note_detector.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/note_detector.sv
// Tone period meter and note classifier: measures the rising-edge to rising-edge
// period of an asynchronous square wave and resolves it to one of seven notes.
module note_detector #(
  parameter int CNT_W       = 20,
  parameter int MAX_PERIOD  = 262143,
  parameter int TOL         = 2000,
  parameter int MATCH_COUNT = 2,
  parameter int P_DO        = 191114,
  parameter int P_RE        = 170264,
  parameter int P_MI        = 151688,
  parameter int P_FA        = 143174,
  parameter int P_SOL       = 127554,
  parameter int P_LA        = 113638,
  parameter int P_SI        = 101240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [2:0]       note,
  output logic             note_valid,
  output logic             silence
);

  typedef logic [CNT_W:0] wide_t;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;
  localparam wide_t      MAX_W   = wide_t'(MAX_PERIOD);
  localparam wide_t      TOL_W   = wide_t'(TOL);
  localparam logic [2:0] MATCH_W = 3'(MATCH_COUNT);

  logic             sync1_r, sync2_r, dly_r;
  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] period_r;
  logic             pv_r;
  logic             silence_r;
  logic [2:0]       note_r;
  logic             nv_r;
  logic [2:0]       run_r;
  logic [2:0]       last_class_r;

  logic             edge_s;
  wide_t            cnt_inc_s;
  logic             timeout_s;
  logic [2:0]       class_s;
  logic [2:0]       run_next_s;

  // Distance to a nominal period, computed one bit wider so it never wraps.
  function automatic logic in_window(input logic [CNT_W-1:0] p, input int nom);
    wide_t pw;
    wide_t nw;
    wide_t d;
    pw = {1'b0, p};
    nw = wide_t'(nom);
    if (pw >= nw) d = pw - nw;
    else          d = nw - pw;
    return (d <= TOL_W);
  endfunction

  function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
    logic [2:0] c;
    if      (in_window(p, P_DO))  c = 3'd1;
    else if (in_window(p, P_RE))  c = 3'd2;
    else if (in_window(p, P_MI))  c = 3'd3;
    else if (in_window(p, P_FA))  c = 3'd4;
    else if (in_window(p, P_SOL)) c = 3'd5;
    else if (in_window(p, P_LA))  c = 3'd6;
    else if (in_window(p, P_SI))  c = 3'd7;
    else                          c = 3'd0;
    return c;
  endfunction

  assign edge_s    = sync2_r & ~dly_r;
  assign cnt_inc_s = {1'b0, cnt_r} + wide_t'(1);
  assign timeout_s = (state_r == MEASURE) && !edge_s && (cnt_inc_s == MAX_W);
  assign class_s   = classify(period_r);

  // Next run length of consecutive identical non-zero classes.
  always_comb begin
    run_next_s = run_r;
    if (class_s == 3'd0) begin
      run_next_s = 3'd0;
    end else if (class_s == last_class_r) begin
      if (run_r >= MATCH_W) run_next_s = MATCH_W;
      else                  run_next_s = run_r + 3'd1;
    end else begin
      run_next_s = 3'd1;
    end
  end

  // Two-flop synchronizer plus delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      dly_r   <= 1'b0;
    end else begin
      sync1_r <= tone_in;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
    end
  end

  // Period measurement FSM; an edge on the timeout cycle takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      period_r  <= {CNT_W{1'b0}};
      pv_r      <= 1'b0;
      silence_r <= 1'b1;
    end else begin
      pv_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (edge_s) state_r <= MEASURE;
        end
        MEASURE: begin
          if (edge_s) begin
            period_r  <= cnt_inc_s[CNT_W-1:0];
            pv_r      <= 1'b1;
            silence_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
          end else if (timeout_s) begin
            state_r   <= IDLE;
            silence_r <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_inc_s[CNT_W-1:0];
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Note confirmation: a class must repeat MATCH_COUNT times before it is shown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      note_r       <= 3'd0;
      nv_r         <= 1'b0;
      run_r        <= 3'd0;
      last_class_r <= 3'd0;
    end else if (timeout_s) begin
      note_r <= 3'd0;
      nv_r   <= 1'b0;
      run_r  <= 3'd0;
    end else if (pv_r) begin
      run_r        <= run_next_s;
      last_class_r <= class_s;
      if (class_s == 3'd0) begin
        note_r <= 3'd0;
        nv_r   <= 1'b0;
      end else if (run_next_s == MATCH_W) begin
        note_r <= class_s;
        nv_r   <= 1'b1;
      end
    end
  end

  assign period       = period_r;
  assign period_valid = pv_r;
  assign note         = note_r;
  assign note_valid   = nv_r;
  assign silence      = silence_r;

endmodule
